// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch timekeeping core.
//   sw_state_t  : run-control FSM states (IDLE, RUN, PAUSE)
//   bcd_digit_t : one 4-bit BCD digit
//   sw_time_t   : SS.HH as four packed digits, MSB digit first, so the
//                 struct maps bit-for-bit onto the 16-bit display bus
//   digit_inc() : saturating-range BCD increment returning {carry, digit}
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t sec_tens;
    bcd_digit_t sec_ones;
    bcd_digit_t hun_tens;
    bcd_digit_t hun_ones;
  } sw_time_t;

  localparam bcd_digit_t HUN_MAX      = 4'd9;
  localparam bcd_digit_t SEC_ONES_MAX = 4'd9;
  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;

  // Increment one digit within 0..max. Comparing with >= rather than == means
  // a digit can never walk past its limit, even from an illegal value.
  function automatic logic [4:0] digit_inc(input bcd_digit_t d, input bcd_digit_t max);
    if (d >= max) return {1'b1, 4'd0};
    else          return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/stopwatch_core_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous slow square wave into the clk domain and turns each
// rising edge into a single-cycle tick. Also used by the display multiplexer
// refresh logic.
//   STAGES   : synchroniser depth, minimum 2
//   clk      : system clock
//   rst      : synchronous, active-high reset
//   async_in : asynchronous input wave
//   tick     : one-cycle pulse per rising edge of async_in
// -----------------------------------------------------------------------------
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic tick
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign tick = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
// Counts elapsed time as BCD SS.HH from the divided 100 Hz square wave, under
// control of a start/stop/clear FSM. clk_div is only ever sampled, never used
// as a clock.
// Optional feature: define STOPWATCH_LAP_EN to add the lap-freeze register.
//   TICK_HZ        : clk_div frequency (informational; counting is in 1/100 s)
//   SYNC_STAGES    : clk_div synchroniser depth, minimum 2
//   clk            : 100 MHz system clock
//   rst            : synchronous, active-high reset
//   clk_div        : asynchronous divided square wave
//   btn_start_stop : one-cycle pulse, toggles run/pause
//   btn_clear      : one-cycle pulse, returns to IDLE and zeroes the count
//   btn_lap        : one-cycle pulse, lap freeze (lap build only)
//   bcd_time       : {sec_tens, sec_ones, hun_tens, hun_ones}
//   running        : high while in RUN
//   wrap           : one-cycle pulse when 59.99 rolls to 00.00
//   lap_active     : display frozen (always 0 without the lap build)
// -----------------------------------------------------------------------------
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_HZ     = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_div,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [15:0] bcd_time,
  output logic        running,
  output logic        wrap,
  output logic        lap_active
);

  // Only elaborates for an illegal configuration, flagging it in the hierarchy.
  if (SYNC_STAGES < 2 || TICK_HZ < 1) begin : g_bad_cfg
    logic cfg_invalid;
    assign cfg_invalid = 1'b1;
  end

  logic      tick;
  sw_state_t state_q, state_d;
  sw_time_t  time_q, time_d;
  logic      wrap_q, wrap_d;

  edge_sync #(
    .STAGES   (SYNC_STAGES)
  ) u_tick_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (clk_div),
    .tick     (tick)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (btn_clear) begin
      state_d = IDLE;
    end else if (btn_start_stop) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    running = (state_q == RUN);
  end

  // ---------------- BCD cascade ----------------
  // Counting is decided on state_q, so a tick arriving with a start/stop press
  // is applied according to the state before the transition.
  always_comb begin
    logic c0, c1, c2, c3;
    c0     = 1'b0;
    c1     = 1'b0;
    c2     = 1'b0;
    c3     = 1'b0;
    time_d = time_q;
    wrap_d = 1'b0;
    if (btn_clear) begin
      time_d = '0;
    end else if (tick && state_q == RUN) begin
      {c0, time_d.hun_ones} = digit_inc(time_q.hun_ones, HUN_MAX);
      if (c0) begin
        {c1, time_d.hun_tens} = digit_inc(time_q.hun_tens, HUN_MAX);
        if (c1) begin
          {c2, time_d.sec_ones} = digit_inc(time_q.sec_ones, SEC_ONES_MAX);
          if (c2) begin
            {c3, time_d.sec_tens} = digit_inc(time_q.sec_tens, SEC_TENS_MAX);
            wrap_d = c3;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      time_q <= time_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

`ifdef STOPWATCH_LAP_EN
  // ---------------- Lap freeze ----------------
  logic     lap_q, lap_d;
  sw_time_t lap_time_q, lap_time_d;

  // The snapshot is the count shown at the press; a tick landing on the same
  // edge moves only the live count.
  always_comb begin
    lap_d      = lap_q;
    lap_time_d = lap_time_q;
    if (btn_clear || state_d == IDLE) begin
      lap_d = 1'b0;
    end else if (btn_lap && state_q != IDLE) begin
      lap_d = ~lap_q;
      if (!lap_q) lap_time_d = time_q;
    end
  end

  // NOTE: the snapshot register is reset as well, even though it is only
  // visible while lap_q is set, so the whole block starts from a known state.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q      <= 1'b0;
      lap_time_q <= '0;
    end else begin
      lap_q      <= lap_d;
      lap_time_q <= lap_time_d;
    end
  end

  assign bcd_time   = lap_q ? lap_time_q : time_q;
  assign lap_active = lap_q;
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign bcd_time       = time_q;
  assign lap_active     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
`timescale 1ns/1ps
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_div;
  logic        btn_start_stop;
  logic        btn_clear;
  logic        btn_lap;
  logic [15:0] bcd_time;
  logic        running;
  logic        wrap;
  logic        lap_active;

  int tests  = 0;
  int failed = 0;

  // Reference model: elapsed time as plain hundredths of a second.
  int m_n;
  bit m_started;
  bit m_run;
  bit m_lap_on;
  int m_lap_val;

  stopwatch_core #(
    .TICK_HZ        (100),
    .SYNC_STAGES    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_div        (clk_div),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .bcd_time       (bcd_time),
    .running        (running),
    .wrap           (wrap),
    .lap_active     (lap_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int n);
    int s;
    int h;
    s = n / 100;
    h = n % 100;
    return {4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clk_div period; inputs change just after a falling clk edge.
  task automatic do_tick(input int hi, input int lo);
    clk_div = 1'b1;
    repeat (hi) @(negedge clk);
    clk_div = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(2, 2);
  endtask

  task automatic pulse(input int which);
    case (which)
      0: btn_start_stop = 1'b1;
      1: btn_clear      = 1'b1;
      default: btn_lap  = 1'b1;
    endcase
    @(negedge clk);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    btn_lap        = 1'b0;
  endtask

  // Raise clk_div and present the buttons in the cycle the internal tick is high.
  task automatic tick_with(input logic ss, input logic clr);
    clk_div = 1'b1;
    repeat (2) @(negedge clk);
    btn_start_stop = ss;
    btn_clear      = clr;
    @(negedge clk);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    clk_div        = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clk_div = 1'b0;
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    btn_lap = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_bcd", bcd_time, 16'h0000);
    check("reset_running", {15'd0, running}, 16'd0);
    check("reset_wrap", {15'd0, wrap}, 16'd0);
    check("reset_lap", {15'd0, lap_active}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ticks in IDLE do nothing.
    ticks(3);
    check("idle_no_count", bcd_time, 16'h0000);

    // Basic count at the scaled 20-clk period.
    pulse(0);
    check("start_running", {15'd0, running}, 16'd1);
    for (int i = 0; i < 150; i++) do_tick(10, 10);
    check("basic_150", bcd_time, 16'h0150);
    check("basic_running", {15'd0, running}, 16'd1);

    // Pause coinciding with a tick at 00.09.
    pulse(1);
    check("clear_bcd", bcd_time, 16'h0000);
    check("clear_running", {15'd0, running}, 16'd0);
    pulse(0);
    ticks(9);
    check("pause_pre", bcd_time, 16'h0009);
    tick_with(1'b1, 1'b0);
    check("pause_count", bcd_time, 16'h0010);
    check("pause_state", {15'd0, running}, 16'd0);
    ticks(5);
    check("pause_hold", bcd_time, 16'h0010);

    // Clear beats start/stop and tick.
    pulse(0);
    check("resume_running", {15'd0, running}, 16'd1);
    ticks(5);
    check("resume_count", bcd_time, 16'h0015);
    tick_with(1'b1, 1'b1);
    check("clrprio_bcd", bcd_time, 16'h0000);
    check("clrprio_running", {15'd0, running}, 16'd0);
    check("clrprio_wrap", {15'd0, wrap}, 16'd0);

    // Wrap from 59.99.
    pulse(0);
    ticks(5998);
    check("wrap_5998", bcd_time, 16'h5998);
    ticks(1);
    check("wrap_5999", bcd_time, 16'h5999);
    check("wrap_not_yet", {15'd0, wrap}, 16'd0);
    clk_div = 1'b1;
    repeat (3) @(negedge clk);
    check("wrap_bcd0", bcd_time, 16'h0000);
    check("wrap_pulse", {15'd0, wrap}, 16'd1);
    check("wrap_running", {15'd0, running}, 16'd1);
    clk_div = 1'b0;
    @(negedge clk);
    check("wrap_one_cycle", {15'd0, wrap}, 16'd0);
    @(negedge clk);
    ticks(1);
    check("wrap_after", bcd_time, 16'h0001);

    // Reset mid-run at 12.34.
    pulse(1);
    pulse(0);
    ticks(1234);
    check("mid_1234", bcd_time, 16'h1234);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bcd", bcd_time, 16'h0000);
    check("midrst_running", {15'd0, running}, 16'd0);
    check("midrst_wrap", {15'd0, wrap}, 16'd0);
    check("midrst_lap", {15'd0, lap_active}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    ticks(3);
    check("midrst_idle", bcd_time, 16'h0000);
    pulse(0);
    ticks(1);
    check("midrst_first", bcd_time, 16'h0001);

`ifdef STOPWATCH_LAP_EN
    pulse(1);
    pulse(2);
    check("lap_idle_ignored", {15'd0, lap_active}, 16'd0);
    pulse(0);
    ticks(321);
    pulse(2);
    check("lap_on", {15'd0, lap_active}, 16'd1);
    check("lap_capture", bcd_time, 16'h0321);
    ticks(100);
    check("lap_frozen", bcd_time, 16'h0321);
    pulse(2);
    check("lap_off", {15'd0, lap_active}, 16'd0);
    check("lap_live", bcd_time, 16'h0421);
    pulse(1);
    check("lap_clear", bcd_time, 16'h0000);
`endif

    // Randomised run against the hundredths model.
    pulse(1);
    m_n = 0;
    m_started = 1'b0;
    m_run = 1'b0;
    m_lap_on = 1'b0;
    m_lap_val = 0;
    for (int step = 0; step < 200; step++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        do_tick(2, int'($urandom_range(2, 4)));
        if (m_run) m_n = (m_n + 1) % 6000;
      end else if (r < 88) begin
        pulse(0);
        if (!m_started) begin
          m_started = 1'b1;
          m_run = 1'b1;
        end else begin
          m_run = !m_run;
        end
      end else if (r < 93) begin
        pulse(1);
        m_n = 0;
        m_started = 1'b0;
        m_run = 1'b0;
        m_lap_on = 1'b0;
      end else begin
        pulse(2);
`ifdef STOPWATCH_LAP_EN
        if (m_started) begin
          if (!m_lap_on) m_lap_val = m_n;
          m_lap_on = !m_lap_on;
        end
`endif
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("rand_bcd", bcd_time, m_lap_on ? to_bcd(m_lap_val) : to_bcd(m_n));
      check("rand_running", {15'd0, running}, {15'd0, m_run});
      check("rand_lap", {15'd0, lap_active}, {15'd0, m_lap_on});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Stopwatch timekeeping core: it consumes the slow square wave from the clock divider and counts elapsed time in BCD, as seconds and hundredths (SS.HH), for the 4-digit seven-segment display. It lives in the 100 MHz `clk_in` domain. The divided clock is synchronised and edge-detected into a one-cycle tick and is never used as a clock. A start/stop/clear FSM gates the counting.

## Interface
- `TICK_HZ`, default 100: frequency of `clk_div`; one rising edge = 1/100 s. Other values are documentation only; count rules are fixed to hundredths.
- `SYNC_STAGES`, default 2: flip-flop stages in the `clk_div` synchroniser. Minimum 2.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_div`  in  1  divided square wave from the clock divider. Asynchronous to `clk` as far as this block is concerned.
- `btn_start_stop`  in  1  one-cycle pulse, already debounced; toggles run/pause.
- `btn_clear`  in  1  one-cycle pulse; zeroes the count.
- `btn_lap`  in  1  one-cycle pulse; lap freeze. Ignored unless `STOPWATCH_LAP_EN` is defined.
- `bcd_time`  out  16  {sec_tens, sec_ones, hun_tens, hun_ones}, 4 bits per digit.
- `running`  out  1  high while in RUN.
- `wrap`  out  1  one-cycle pulse when 59.99 rolls to 00.00.
- `lap_active`  out  1  display frozen. Tied 0 when the macro is undefined.

## Operation
- **Tick generation**
  - `clk_div` passes through `SYNC_STAGES` flops, then one more history flop.
  - `tick` = synced & ~history, so there is exactly one `tick` per rising edge of `clk_div`.
- **FSM states:** IDLE, RUN, PAUSE.
  - IDLE → RUN on `btn_start_stop`.
  - RUN → PAUSE on `btn_start_stop`.
  - PAUSE → RUN on `btn_start_stop`.
  - Any state → IDLE on `btn_clear`. This also zeroes all digits.
- **Counting:** only in RUN, only on `tick`.
  - `hun_ones` 0–9 carries into `hun_tens` 0–9.
  - `hun_tens` carries into `sec_ones` 0–9.
  - `sec_ones` carries into `sec_tens` 0–5.
  - At 59.99, a tick sets the count to 00.00, asserts `wrap` for one cycle and stays in RUN.
  - Digits never hold a non-BCD value, and `sec_tens` never exceeds 5.
- **Simultaneous events**
  - `btn_clear` has priority over `btn_start_stop`, `btn_lap` and `tick`.
  - `tick` together with `btn_start_stop`: the tick is applied according to the state before the transition. In RUN it counts and then pauses; from PAUSE it does not count.
  - `btn_start_stop` together with `btn_lap`: both take effect.
- **Reset:** `rst` sampled high on a `clk` edge gives, at that edge:
  - state IDLE;
  - all digits 0, `bcd_time` = 16'h0000;
  - `running` = 0, `wrap` = 0, `lap_active` = 0;
  - synchroniser and history flops = 0.
- **Reset mid-run:** the count is discarded and no `wrap` is generated. The first `clk_div` rising edge seen after reset release produces a normal tick.

## Timing
- `tick` asserts `SYNC_STAGES`+1 `clk` cycles after the `clk_div` rising edge, ±1 cycle for metastability.
- All outputs are registered.
- **Button response**
  - `running` changes on the edge after the button pulse is sampled (1-cycle latency).
  - `btn_clear` zeroes `bcd_time` on the same edge that samples it.
- **Count update:** the internal count and `bcd_time` update on the edge after `tick`.
- **wrap:** asserts in the same cycle that `bcd_time` shows 0000 after the roll-over.
- **Button timing:** buttons may arrive in any cycle. There is no minimum spacing between pulses, and pulses held longer than one cycle are processed on every cycle they are high.

## Configuration
- **`STOPWATCH_LAP_EN` defined**
  - `btn_lap` in RUN or PAUSE toggles `lap_active`.
  - While `lap_active` = 1, `bcd_time` holds the value captured at the lap press, and the internal count keeps running.
  - `btn_clear` or a transition to IDLE clears `lap_active`.
  - `btn_lap` in IDLE is ignored.
- **Undefined**
  - `bcd_time` always shows the live count and `btn_lap` is ignored.
  - `lap_active` is tied 0.
  - No lap capture register is synthesised.

## Structure
- **Package `stopwatch_pkg`**
  - state enum `sw_state_t` {IDLE, RUN, PAUSE};
  - `bcd_digit_t` (4-bit);
  - constants `HUN_MAX`=9, `SEC_ONES_MAX`=9, `SEC_TENS_MAX`=5.
- **Sub-module `edge_sync`:** parameterised synchroniser plus rising-edge detector. It outputs `tick` and is reused by the display multiplexer refresh logic.
- **Top:** FSM, BCD cascade and, when enabled, the lap register.

## Test plan
- **Basic count:** reset, pulse `btn_start_stop`, drive `clk_div` at 100 Hz (scaled: a period of 20 `clk`) for 150 edges → `bcd_time` = 16'h0150, `running` = 1.
- **Wrap:** preload to 59.98 by counting 5998 ticks, apply 2 more ticks → 16'h5999, then 16'h0000 with a single-cycle `wrap`, still RUN.
- **Pause:** in RUN, pulse `btn_start_stop` in the same cycle as `tick` at 00.09 → count 00.10, then PAUSE. Further ticks leave 16'h0010.
- **Clear priority:** in RUN, assert `btn_clear`, `btn_start_stop` and `tick` together → state IDLE, `bcd_time` 16'h0000, `running` 0.
- **Reset mid-run:** assert `rst` at 12.34 → next cycle all outputs 0 and IDLE. After release, ticks are ignored until `btn_start_stop`.
- **Lap (macro defined):** `btn_lap` at 03.21, then 100 more ticks → `bcd_time` holds 16'h0321. A second `btn_lap` → 16'h0421.
